// File: rtl/multicycle_ctrl_pkg.sv
// Shared RV32I control types: opcode values, mux selects, FSM states and instruction classes.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_ALU   = 2'd1
  } pc_src_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP
  } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/memory side (slave).
interface multicycle_ctrl_if;
  import rv32i_pkg::*;

  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;

  logic        mem_req;
  logic        mem_we;
  logic        mem_is_ifetch;
  logic        ir_we;
  logic        pc_we;
  pc_src_t     pc_src;
  imm_sel_t    imm_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        reg_we;
  wb_sel_t     wb_sel;
  logic        illegal;

  modport master (
    input  instr, branch_taken, mem_ready,
    output mem_req, mem_we, mem_is_ifetch, ir_we, pc_we, pc_src, imm_sel,
           alu_a_sel, alu_b_sel, reg_we, wb_sel, illegal
  );

  modport slave (
    output instr, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_is_ifetch, ir_we, pc_we, pc_src, imm_sel,
           alu_a_sel, alu_b_sel, reg_we, wb_sel, illegal
  );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Opcode decoder: instruction class, immediate format and ALU operand selects.
// Latency: purely combinational.
// Backpressure: none; consumes only the opcode field of IR.
module ctrl_decode
  import rv32i_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output imm_sel_t     imm_sel,
  output logic         alu_a_sel,
  output logic         alu_b_sel,
  output logic         legal
);

  // Only the opcode steers control; remaining IR fields feed the datapath directly.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:7];

  always_comb begin
    cls       = CLS_ALU;
    imm_sel   = IMM_I;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    legal     = 1'b1;
    case (instr[6:0])
      OPC_OP: ;
      OPC_OP_IMM: alu_b_sel = 1'b1;
      OPC_LOAD: begin
        cls       = CLS_LOAD;
        alu_b_sel = 1'b1;
      end
      OPC_STORE: begin
        cls       = CLS_STORE;
        imm_sel   = IMM_S;
        alu_b_sel = 1'b1;
      end
      OPC_BRANCH: begin
        cls       = CLS_BRANCH;
        imm_sel   = IMM_B;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
      end
      OPC_JAL: begin
        cls       = CLS_JUMP;
        imm_sel   = IMM_J;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
      end
      OPC_JALR: begin
        cls       = CLS_JUMP;
        alu_b_sel = 1'b1;
      end
      OPC_LUI: begin
        imm_sel   = IMM_U;
        alu_b_sel = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel   = IMM_U;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a trap state for bad opcodes.
// Latency: branch 3, ALU/jump/store 4, load 5 cycles plus one per memory wait cycle.
// Backpressure: mem_req held in FETCH/MEM until mem_ready; all outputs forced low while rst.
module multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter bit RESET_TRAP_STICKY = 1'b1
)(
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  ctrl_state_t  state;
  ctrl_state_t  state_nxt;
  instr_class_t dec_cls;
  imm_sel_t     dec_imm_sel;
  logic         dec_alu_a_sel;
  logic         dec_alu_b_sel;
  logic         dec_legal;

  ctrl_decode u_decode (
    .instr     (bus.instr),
    .cls       (dec_cls),
    .imm_sel   (dec_imm_sel),
    .alu_a_sel (dec_alu_a_sel),
    .alu_b_sel (dec_alu_b_sel),
    .legal     (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_is_ifetch = 1'b0;
    bus.ir_we         = 1'b0;
    bus.pc_we         = 1'b0;
    bus.pc_src        = PC_PLUS4;
    bus.imm_sel       = IMM_I;
    bus.alu_a_sel     = 1'b0;
    bus.alu_b_sel     = 1'b0;
    bus.reg_we        = 1'b0;
    bus.wb_sel        = WB_ALU;
    bus.illegal       = 1'b0;

    // IR is stable from DECODE to WB, so decoded selects are simply held there.
    if (!rst && state inside {ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB}) begin
      bus.imm_sel   = dec_imm_sel;
      bus.alu_a_sel = dec_alu_a_sel;
      bus.alu_b_sel = dec_alu_b_sel;
    end

    if (!rst) begin
      case (state)
        ST_FETCH: begin
          bus.mem_req       = 1'b1;
          bus.mem_is_ifetch = 1'b1;
          bus.ir_we         = bus.mem_ready;
          bus.pc_we         = bus.mem_ready;
          if (bus.mem_ready) state_nxt = ST_DECODE;
        end
        ST_DECODE: begin
          if (dec_legal) begin
            state_nxt = ST_EXECUTE;
          end else begin
            bus.illegal = 1'b1;
            state_nxt   = ST_TRAP;
          end
        end
        ST_EXECUTE: begin
          case (dec_cls)
            CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
            CLS_BRANCH: begin
              bus.pc_we  = bus.branch_taken;
              bus.pc_src = PC_ALU;
              state_nxt  = ST_FETCH;
            end
            default: state_nxt = ST_WB;
          endcase
        end
        ST_MEM: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = (dec_cls == CLS_STORE);
          if (bus.mem_ready) state_nxt = (dec_cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB: begin
          bus.reg_we = 1'b1;
          state_nxt  = ST_FETCH;
          if (dec_cls == CLS_LOAD) begin
            bus.wb_sel = WB_LOAD;
          end else if (dec_cls == CLS_JUMP) begin
            bus.wb_sel = WB_PC4;
            bus.pc_we  = 1'b1;
            bus.pc_src = PC_ALU;
          end
        end
        ST_TRAP: begin
          bus.illegal = 1'b1;
          if (!RESET_TRAP_STICKY) state_nxt = ST_FETCH;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

endmodule
